// File: rtl/dnn_mem_port_arbiter_pkg.sv
// Shared types and memory geometry for the s2 port arbiter of the 1024x32 on-chip
// buffer RAM.
package dnn_mem_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dnn_mem_port_arbiter_if.sv
// Bundle of requester beats, read responses and the Avalon-MM style s2 memory port.
//
// Handshake: a beat from requester i transfers on a rising edge where rq_valid[i] and
// rq_ready[i] are both high. rq_ready is a same-cycle function of rq_valid, so a
// requester must not wait for ready before raising valid, and must hold its fields
// stable while valid is high. rs_valid is a one-cycle one-hot pulse with no
// back-pressure; writes never produce a response.
interface dnn_mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [1:0]          rq_valid;
    logic [1:0]          rq_ready;
    logic [1:0]          rq_write;
    logic [1:0]          rq_last;
    logic [2*ADDR_W-1:0] rq_addr;
    logic [2*DATA_W-1:0] rq_wdata;
    logic [2*BE_W-1:0]   rq_be;
    logic [1:0]          rs_valid;
    logic [DATA_W-1:0]   rs_rdata;
    logic [ADDR_W-1:0]   mem_address;
    logic [BE_W-1:0]     mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic [DATA_W-1:0]   mem_readdata;

    // Requesters plus the RAM: drives beats and read data, observes everything else.
    modport master (
        output rq_valid, rq_write, rq_last, rq_addr, rq_wdata, rq_be, mem_readdata,
        input  rq_ready, rs_valid, rs_rdata,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
    );

    // The arbiter.
    modport slave (
        input  rq_valid, rq_write, rq_last, rq_addr, rq_wdata, rq_be, mem_readdata,
        output rq_ready, rs_valid, rs_rdata,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
    );
endinterface

// File: rtl/dnn_mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that was not
// served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dnn_mem_port_arbiter.sv
// Round-robin arbiter with burst lock sharing RAM port s2 between the loader (req0)
// and the result writer (req1); read responses are routed back by a tag pipeline.
module dnn_mem_port_arbiter
    import dnn_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int BE_W       = MEM_BE_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dnn_mem_port_arbiter_if.slave  bus,
    output arb_state_e             state_dbg
);

    arb_state_e        state_q, state_d;
    logic              last_q;
    logic [1:0]        rr_gnt;
    logic [1:0]        gnt;
    logic              accept;
    logic              g;
    logic [1:0]        tag_q [RD_LATENCY];
    logic [1:0]        tag_out;
    logic [1:0]        rs_valid_q;
    logic [DATA_W-1:0] rs_rdata_q;

    rr_arb2 u_rr_arb2 (
        .req  (bus.rq_valid),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // Gating with reset_n keeps the combinational memory strobes quiet while reset is held.
    always_comb begin
        gnt = 2'b00;
        case (state_q)
            ARB_OWN0: gnt = {1'b0, bus.rq_valid[0]};
            ARB_OWN1: gnt = {bus.rq_valid[1], 1'b0};
            default:  gnt = rr_gnt;
        endcase
        if (!reset_n) gnt = 2'b00;
    end

    assign accept = |gnt;
    assign g      = gnt[1];

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (bus.rq_last[g]) state_d = ARB_IDLE;
            else                state_d = g ? ARB_OWN1 : ARB_OWN0;
        end
    end

    assign bus.rq_ready       = gnt;
    assign bus.mem_chipselect = accept;
    assign bus.mem_write      = accept & bus.rq_write[g];
    assign bus.mem_address    = !accept ? '0 :
                                g ? bus.rq_addr[2*ADDR_W-1:ADDR_W] : bus.rq_addr[ADDR_W-1:0];
    assign bus.mem_byteenable = !accept ? '0 :
                                g ? bus.rq_be[2*BE_W-1:BE_W] : bus.rq_be[BE_W-1:0];
    assign bus.mem_writedata  = !accept ? '0 :
                                g ? bus.rq_wdata[2*DATA_W-1:DATA_W] : bus.rq_wdata[DATA_W-1:0];

    assign tag_out = tag_q[RD_LATENCY-1];

    // The tag travels alongside the RAM read latency so the response lines up with readdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            last_q     <= 1'b1;
            for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= 2'b00;
            rs_valid_q <= 2'b00;
            rs_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) last_q <= g;
            tag_q[0] <= (accept && !bus.rq_write[g]) ? gnt : 2'b00;
            for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            rs_valid_q <= tag_out;
            rs_rdata_q <= (tag_out != 2'b00) ? bus.mem_readdata : '0;
        end
    end

    assign bus.rs_valid = rs_valid_q;
    assign bus.rs_rdata = rs_rdata_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/dnn_mem_port_arbiter.md
Name: dnn_mem_port_arbiter

Overview:
- Shares port s2 of the 1024x32 dual-port on-chip buffer RAM between two accelerator requesters: req0 is the weight/activation loader and req1 is the result writer.
- Port s1 remains with the HPS bridge.
- Provides round-robin arbitration with burst lock, and issues Avalon-MM style single-word accesses to s2.
- Routes each read response back to the requester that issued it.

Parameters:
- ADDR_W, 10, word address width of s2.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- RD_LATENCY, 1, cycles from accepted read to valid mem_readdata. Legal values are 1 or 2.

Ports:
- clk  in  1  single clock, shared with the memory's clk2.
- reset_n  in  1  asynchronous, active-low reset.
- rq_valid  in  2  per-requester beat valid; bit i belongs to requester i.
- rq_ready  out  2  per-requester beat accepted, asserted in the same cycle as the handshake.
- rq_write  in  2  1 = write beat, 0 = read beat.
- rq_last  in  2  final beat of a locked burst.
- rq_addr  in  2*ADDR_W  packed word addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- rq_wdata  in  2*DATA_W  packed write data.
- rq_be  in  2*BE_W  packed byte enables.
- rs_valid  out  2  read response valid, one-hot.
- rs_rdata  out  DATA_W  read data, meaningful only while rs_valid is nonzero.
- mem_address  out  ADDR_W  to address2.
- mem_byteenable  out  BE_W  to byteenable2.
- mem_chipselect  out  1  to chipselect2.
- mem_write  out  1  to write2.
- mem_writedata  out  DATA_W  to writedata2.
- mem_readdata  in  DATA_W  from readdata2.

Behaviour:
- FSM states:
  - IDLE: no owner.
  - OWN0: burst locked to requester 0.
  - OWN1: burst locked to requester 1.
- Reset values:
  - State = IDLE.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - rq_ready = 0, rs_valid = 0, rs_rdata = 0.
  - All mem_* outputs = 0.
  - Read-tag pipeline cleared.
- Grant selection (combinational):
  - IDLE with one valid requester: that requester is granted.
  - IDLE with both valid: the requester != last is granted.
  - OWNi: only requester i can be granted. A valid from the other requester is ignored and its rq_ready stays 0.
- rq_ready[i] = rq_valid[i] & granted(i). No bubble cycles: a beat is accepted in the same cycle it is granted.
- Memory issue (combinational from the granted requester):
  - mem_chipselect = accept.
  - mem_write = accept & rq_write[g].
  - Address, byte enables and write data are muxed from requester g.
  - When there is no accept, mem_* are driven to 0.
- State transitions on an accepted beat from requester g:
  - rq_last[g] = 0: next state OWNg.
  - rq_last[g] = 1: next state IDLE.
  - In both cases last <= g.
  - A single-beat access is valid together with last; it leaves the FSM in IDLE.
- Burst hold: in OWNi with rq_valid[i] = 0, the FSM stays in OWNi. The lock is held through gaps until the last beat.
- Read tags:
  - An accepted read pushes the one-hot tag (1<<g) into a RD_LATENCY-deep shift register. Writes push 0.
  - At the output: rs_valid = tag_out and rs_rdata = mem_readdata, both registered.
  - Read response latency = RD_LATENCY + 1 cycles after acceptance.
  - Back-to-back reads are fully pipelined, at one per cycle.
- Mixed reads and writes: responses stay in issue order. Writes produce no response.
- Reset mid-burst: the lock is released, in-flight read tags are discarded and no rs_valid is emitted. The lost reads are the requesters' responsibility to reissue.
- No address wrap logic is needed: the address is a full ADDR_W word index.

Decomposition:
- Package dnn_mem_pkg holds:
  - The FSM state enum (ARB_IDLE, ARB_OWN0, ARB_OWN1).
  - Constants MEM_ADDR_W = 10, MEM_DATA_W = 32, MEM_BE_W = 4.
- Sub-module rr_arb2 (combinational two-way round-robin pick). Inputs: req[1:0], last. Outputs: gnt one-hot.
  - The parent adds the lock FSM and the tag pipeline.

Test Plan:
- Single read: after reset, req0 reads addr 0x005 (memory preloaded with 0xA5A5_0005). Expected:
  - rq_ready[0] = 1 in the same cycle.
  - mem_address = 0x005, mem_write = 0.
  - rs_valid = 2'b01 with rs_rdata = 0xA5A5_0005 exactly 2 cycles later.
- Tie and round-robin: both requesters hold single-beat reads (last = 1) continuously. Expected grants 0,1,0,1 on consecutive cycles, with no idle cycle.
- Burst lock: req1 sends 4 write beats to addr 0x3FC..0x3FF, data 0x1111_0000+i, be = 4'hF, last on beat 4, with a 2-cycle valid gap after beat 2; req0 is valid throughout. Expected:
  - rq_ready[0] stays 0 until the cycle after req1's last beat.
  - Readback of 0x3FF = 0x1111_0003.
- Byte enables: write 0xDEAD_BEEF with be = 4'b0101 over 0x0000_0000 at addr 0x010, then read it back. Expected rs_rdata = 0x00AD_00EF.
- Interleaved read routing: req0 reads 0x001 (last), then req1 reads 0x002 (last) on the next cycle. Expected:
  - rs_valid = 01 followed by 10 on consecutive cycles.
  - Each carries the correct data.
- Reset mid-burst: assert reset_n = 0 one cycle after a req0 read is accepted inside a burst. Expected:
  - All outputs 0 immediately (asynchronous).
  - No rs_valid after release.
  - FSM back in IDLE, with req0 winning the next tie.
